// File: rtl/sha256_block_driver.sv
// SHA-256 block driver: pads a word stream into 512-bit blocks, sequences the compression core and returns the digest.
// Build option SHA256_DRIVER_CUSTOM_IV_EN adds iv_in, used instead of the standard IV as the starting chain value.
module sha256_block_driver #(
    parameter int unsigned MAX_WORDS = 255,
    parameter int unsigned LEN_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_words,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             core_start,
    output logic [511:0]     core_msg,
    output logic [255:0]     core_h_in,
    input  logic             core_done,
    input  logic [255:0]     core_h_out,
    output logic             busy,
    output logic             done,
    output logic [255:0]     digest,
`ifdef SHA256_DRIVER_CUSTOM_IV_EN
    input  logic [255:0]     iv_in,
`endif
    output logic             err
);

    localparam int unsigned MAX_BLOCKS = (MAX_WORDS + 2) / 16 + 1;
    localparam int unsigned G_W        = $clog2(MAX_BLOCKS * 16 + 1);
    localparam int unsigned B_W        = $clog2(MAX_BLOCKS + 1);
    localparam logic [31:0]  PAD_WORD  = 32'h8000_0000;
    localparam logic [255:0] STD_IV    =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  n_q, n_d;
    logic [G_W-1:0]    g_q, g_d;
    logic [B_W-1:0]    blk_q, blk_d;
    logic [B_W-1:0]    nblk_q, nblk_d;
    logic [15:0][31:0] blk_buf_q, blk_buf_d;
    logic [255:0]      chain_q, chain_d;
    logic [255:0]      digest_q, digest_d;
    logic              in_ready_q, in_ready_d;
    logic              core_start_q, core_start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [3:0]        slot;
    logic              last_blk;
    logic [31:0]       len_word;
    logic              adv;

    // Blocks are 16-word aligned in the padded stream, so the slot is the low nibble of g.
    assign slot     = g_q[3:0];
    assign last_blk = (blk_q + B_W'(1)) == nblk_q;
    assign len_word = 32'(n_q) << 5;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        g_d       = g_q;
        blk_d     = blk_q;
        nblk_d    = nblk_q;
        blk_buf_d = blk_buf_q;
        chain_d   = chain_q;
        digest_d  = digest_q;
        err_d     = 1'b0;
        adv       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (32'(msg_words) > MAX_WORDS) begin
                        err_d = 1'b1;
                    end else begin
                        n_d       = msg_words;
                        nblk_d    = B_W'(((32'(msg_words) + 32'd2) >> 4) + 32'd1);
                        g_d       = '0;
                        blk_d     = '0;
                        blk_buf_d = '0;
`ifdef SHA256_DRIVER_CUSTOM_IV_EN
                        chain_d   = iv_in;
`else
                        chain_d   = STD_IV;
`endif
                        state_d   = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (32'(g_q) < 32'(n_q)) begin
                    if (in_valid && in_ready_q) begin
                        blk_buf_d[4'd15 - slot] = in_data;
                        adv = 1'b1;
                    end
                end else if (32'(g_q) == 32'(n_q)) begin
                    blk_buf_d[4'd15 - slot] = PAD_WORD;
                    adv = 1'b1;
                end else begin
                    // Slot 14 of the last block is the zero upper length word.
                    blk_buf_d[4'd15 - slot] = (last_blk && slot == 4'd15) ? len_word : 32'h0;
                    adv = 1'b1;
                end
                if (adv) begin
                    g_d = g_q + G_W'(1);
                    if (slot == 4'd15) begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done) begin
                    chain_d = core_h_out;
                    blk_d   = blk_q + B_W'(1);
                    if (!last_blk) begin
                        blk_buf_d = '0;
                        state_d   = ST_LOAD;
                    end else begin
                        digest_d = core_h_out;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered handshakes are derived from the upcoming state.
        in_ready_d   = (state_d == ST_LOAD) && (32'(g_d) < 32'(n_d));
        core_start_d = (state_d == ST_ISSUE);
        busy_d       = (state_d == ST_LOAD) || (state_d == ST_ISSUE) || (state_d == ST_WAIT);
        done_d       = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            n_q          <= '0;
            g_q          <= '0;
            blk_q        <= '0;
            nblk_q       <= '0;
            blk_buf_q    <= '0;
            chain_q      <= '0;
            digest_q     <= '0;
            in_ready_q   <= 1'b0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            g_q          <= g_d;
            blk_q        <= blk_d;
            nblk_q       <= nblk_d;
            blk_buf_q    <= blk_buf_d;
            chain_q      <= chain_d;
            digest_q     <= digest_d;
            in_ready_q   <= in_ready_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign core_start = core_start_q;
    assign core_msg   = blk_buf_q;
    assign core_h_in  = chain_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign digest     = digest_q;
    assign err        = err_q;

endmodule

// File: tb/tb_sha256_block_driver.sv
// Bench for sha256_block_driver: software SHA-256 core model plus a block scoreboard fed by a reference padder.
module tb_sha256_block_driver;

    localparam int CORE_LAT = 5;
    localparam logic [255:0] STD_IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] SHA_EMPTY =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [15:0]  msg_words;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         in_ready;
    logic         core_start;
    logic [511:0] core_msg;
    logic [255:0] core_h_in;
    logic         core_done;
    logic [255:0] core_h_out;
    logic         busy;
    logic         done;
    logic [255:0] digest;
    logic         err;

    int n_tests = 0;
    int n_fail  = 0;
    int starts  = 0;

    logic [511:0] exp_msg_q[$];
    logic [255:0] exp_hin_q[$];
    logic [31:0]  feed_q[$];
    int           feed_idx  = 0;
    int           stall_at  = 0;
    int           stall_len = 0;
    int           stall_cnt = 0;

    always #5 clk = ~clk;

    sha256_block_driver #(.MAX_WORDS(255), .LEN_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .msg_words  (msg_words),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .core_start (core_start),
        .core_msg   (core_msg),
        .core_h_in  (core_h_in),
        .core_done  (core_done),
        .core_h_out (core_h_out),
        .busy       (busy),
        .done       (done),
        .digest     (digest),
`ifdef SHA256_DRIVER_CUSTOM_IV_EN
        .iv_in      (STD_IV),
`endif
        .err        (err)
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] m);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    // Compression core model: fixed latency, one block at a time.
    always begin : core_model
        logic [511:0] cm;
        logic [255:0] ch;
        @(negedge clk);
        if (core_start === 1'b1) begin
            cm = core_msg;
            ch = core_h_in;
            repeat (CORE_LAT) @(negedge clk);
            core_h_out = sha_compress(ch, cm);
            core_done  = 1'b1;
            @(negedge clk);
            core_done  = 1'b0;
        end
    end

    // Word source with an optional stall after stall_at accepted words.
    always @(negedge clk) begin
        if (stall_cnt > 0) begin
            in_valid = 1'b0;
            stall_cnt--;
        end else if (feed_idx < feed_q.size()) begin
            in_valid = 1'b1;
            in_data  = feed_q[feed_idx];
        end else begin
            in_valid = 1'b0;
        end
        if (in_valid && in_ready === 1'b1) begin
            feed_idx++;
            if (feed_idx == stall_at) stall_cnt = stall_len;
        end
    end

    // Scoreboard: every issued block is checked against the reference padder's next entry.
    always @(negedge clk) begin
        if (core_start === 1'b1) begin
            starts++;
            n_tests++;
            if (exp_msg_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_start: core_start with no expected block, core_msg=%h", core_msg);
            end else begin
                logic [511:0] em;
                logic [255:0] eh;
                em = exp_msg_q.pop_front();
                eh = exp_hin_q.pop_front();
                if (core_msg !== em) begin
                    n_fail++;
                    $display("FAIL sb_core_msg: got %h expected %h", core_msg, em);
                end
                n_tests++;
                if (core_h_in !== eh) begin
                    n_fail++;
                    $display("FAIL sb_core_h_in: got %h expected %h", core_h_in, eh);
                end
            end
        end
    end

    task automatic prepare(input int n, input int s_at, input int s_len,
                           output logic [255:0] exp_dig, output int nblk);
        logic [31:0]  stream[$];
        logic [511:0] m;
        logic [255:0] h;
        for (int i = 0; i < n; i++) stream.push_back(feed_q[i]);
        stream.push_back(32'h8000_0000);
        while (stream.size() % 16 != 14) stream.push_back(32'h0);
        stream.push_back(32'h0);
        stream.push_back(32'(n * 32));
        nblk = stream.size() / 16;
        h = STD_IV;
        for (int b = 0; b < nblk; b++) begin
            for (int w = 0; w < 16; w++) m[511 - 32*w -: 32] = stream[b*16 + w];
            exp_msg_q.push_back(m);
            exp_hin_q.push_back(h);
            h = sha_compress(h, m);
        end
        exp_dig   = h;
        feed_idx  = 0;
        stall_at  = s_at;
        stall_len = s_len;
        stall_cnt = 0;
    endtask

    task automatic do_start(input int n);
        @(negedge clk);
        msg_words = 16'(n);
        start     = 1'b1;
    endtask

    task automatic run_to_done(input int budget, input int restart_at, output int lat,
                               output bit got_done, output logic [255:0] dig,
                               output int errs, output bit ready_gap);
        lat = -1; got_done = 1'b0; dig = '0; errs = 0; ready_gap = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start = (c == restart_at);
            if (c == restart_at) msg_words = 16'd300;
            if (err === 1'b1) errs++;
            if (core_start === 1'b1 && lat < 0) lat = c;
            if (lat < 0 && in_ready !== 1'b1) ready_gap = 1'b1;
            if (done === 1'b1) begin
                got_done = 1'b1;
                dig = digest;
                break;
            end
        end
    endtask

    task automatic test_reset;
        n_tests++;
        if ({in_ready, core_start, busy, done, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000", {in_ready, core_start, busy, done, err});
        end
        n_tests++;
        if (core_msg !== '0) begin n_fail++; $display("FAIL reset_core_msg: got %h expected 0", core_msg); end
        n_tests++;
        if (core_h_in !== '0) begin n_fail++; $display("FAIL reset_core_h_in: got %h expected 0", core_h_in); end
        n_tests++;
        if (digest !== '0) begin n_fail++; $display("FAIL reset_digest: got %h expected 0", digest); end
    endtask

    task automatic test_empty;
        logic [255:0] ed, dig;
        int nb, lat, errs, s0;
        bit gd, gap;
        feed_q.delete();
        prepare(0, 0, 0, ed, nb);
        s0 = starts;
        do_start(0);
        run_to_done(300, 0, lat, gd, dig, errs, gap);
        n_tests++;
        if (!gd) begin n_fail++; $display("FAIL empty_done: no done within budget"); end
        n_tests++;
        if (lat != 17) begin n_fail++; $display("FAIL empty_latency: core_start at cycle %0d expected 17", lat); end
        n_tests++;
        if (dig !== SHA_EMPTY) begin n_fail++; $display("FAIL empty_digest: got %h expected %h", dig, SHA_EMPTY); end
        @(negedge clk);
        n_tests++;
        if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL empty_done_once: done,busy=%b expected 00", {done, busy}); end
        n_tests++;
        if (starts - s0 != nb) begin n_fail++; $display("FAIL empty_starts: got %0d expected %0d", starts - s0, nb); end
    endtask

    task automatic test_abcd_and_busy_start;
        logic [255:0] ed, dig;
        int nb, lat, errs, s0;
        bit gd, gap;
        feed_q.delete();
        feed_q.push_back(32'h6162_6364);
        prepare(1, 0, 0, ed, nb);
        s0 = starts;
        do_start(1);
        run_to_done(300, 4, lat, gd, dig, errs, gap);
        n_tests++;
        if (!gd || dig !== ed) begin n_fail++; $display("FAIL abcd_digest: got %h expected %h (done=%0d)", dig, ed, gd); end
        n_tests++;
        if (errs != 0) begin n_fail++; $display("FAIL busy_start_err: got %0d err pulses expected 0", errs); end
        repeat (3) @(negedge clk);
        n_tests++;
        if (starts - s0 != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start_effect: starts %0d busy %b expected 1 and 0", starts - s0, busy);
        end
    endtask

    task automatic test_two_block;
        logic [255:0] ed, dig;
        int nb, lat, errs, s0;
        bit gd, gap;
        feed_q.delete();
        for (int i = 1; i <= 14; i++) feed_q.push_back(32'(i));
        prepare(14, 0, 0, ed, nb);
        s0 = starts;
        do_start(14);
        run_to_done(400, 0, lat, gd, dig, errs, gap);
        n_tests++;
        if (!gd || dig !== ed) begin n_fail++; $display("FAIL two_block_digest: got %h expected %h (done=%0d)", dig, ed, gd); end
        n_tests++;
        if (starts - s0 != 2) begin n_fail++; $display("FAIL two_block_starts: got %0d expected 2", starts - s0); end
    endtask

    task automatic test_stall;
        logic [255:0] ed, dig;
        int nb, lat, errs, s0;
        bit gd, gap;
        feed_q.delete();
        for (int i = 0; i < 20; i++) feed_q.push_back(32'hA500_0000 | 32'(i));
        prepare(20, 5, 3, ed, nb);
        s0 = starts;
        do_start(20);
        run_to_done(400, 0, lat, gd, dig, errs, gap);
        n_tests++;
        if (lat != 20) begin n_fail++; $display("FAIL stall_load_len: core_start at cycle %0d expected 20", lat); end
        n_tests++;
        if (gap) begin n_fail++; $display("FAIL stall_in_ready: in_ready dropped during first load"); end
        n_tests++;
        if (!gd || dig !== ed) begin n_fail++; $display("FAIL stall_digest: got %h expected %h (done=%0d)", dig, ed, gd); end
        n_tests++;
        if (feed_idx != 20 || starts - s0 != 2) begin
            n_fail++;
            $display("FAIL stall_words: consumed %0d blocks %0d expected 20 and 2", feed_idx, starts - s0);
        end
    endtask

    task automatic test_reset_mid;
        logic [255:0] ed, dig;
        int nb, lat, errs, hi;
        bit gd, gap, seen;
        feed_q.delete();
        prepare(0, 0, 0, ed, nb);
        do_start(0);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (core_start === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL rst_mid_issue: no core_start within budget"); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_tests++;
        if ({in_ready, core_start, busy, done, err} !== 5'b0 || core_msg !== '0 || core_h_in !== '0 || digest !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: ctrl %b msg %h h_in %h digest %h expected all 0",
                     {in_ready, core_start, busy, done, err}, core_msg, core_h_in, digest);
        end
        hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1 || core_start === 1'b1) hi++;
        end
        n_tests++;
        if (hi != 0) begin n_fail++; $display("FAIL rst_mid_late_done: %0d active cycles expected 0", hi); end
        prepare(0, 0, 0, ed, nb);
        do_start(0);
        run_to_done(300, 0, lat, gd, dig, errs, gap);
        n_tests++;
        if (!gd || dig !== SHA_EMPTY) begin n_fail++; $display("FAIL rst_mid_rerun: got %h expected %h (done=%0d)", dig, SHA_EMPTY, gd); end
    endtask

    task automatic test_err;
        int errs, busy_hi, s0;
        s0 = starts; errs = 0; busy_hi = 0;
        @(negedge clk);
        msg_words = 16'd256;
        start     = 1'b1;
        repeat (10) begin
            @(negedge clk);
            start = 1'b0;
            if (err === 1'b1) errs++;
            if (busy === 1'b1) busy_hi++;
        end
        n_tests++;
        if (errs != 1) begin n_fail++; $display("FAIL err_pulse: got %0d pulses expected 1", errs); end
        n_tests++;
        if (busy_hi != 0 || starts != s0) begin
            n_fail++;
            $display("FAIL err_no_effect: busy cycles %0d core_starts %0d expected 0 and 0", busy_hi, starts - s0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        msg_words  = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        core_done  = 1'b0;
        core_h_out = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_empty();
        test_abcd_and_busy_start();
        test_two_block();
        test_stall();
        test_reset_mid();
        test_err();
        n_tests++;
        if (exp_msg_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: %0d expected blocks never issued", exp_msg_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
